// File: rtl/demux_1to3_buffered.sv
// demux_1to3_buffered: routes one word per cycle to one of three one-entry output registers.
// Optional DEMUX_DROP_COUNT_EN adds a saturating count of words dropped via select 2'b11.
module demux_1to3_buffered #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data
`ifdef DEMUX_DROP_COUNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);
  logic [WIDTH-1:0] data [3];
  logic [2:0]       full;
  logic [3:0]       busy;
  logic             accept;
  // Index 3 is the drop code and is never busy.
  always_comb begin
    busy     = {1'b0, full & ~out_ready};
    in_ready = ~busy[in_sel];
    accept   = in_valid & in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < 3; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept && in_sel == 2'(i)) begin
          data[i] <= in_data;
          full[i] <= 1'b1;
        end else if (out_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end
`ifdef DEMUX_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else if (accept && in_sel == 2'b11 && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif
  assign out_valid = full;
  assign out0_data = data[0];
  assign out1_data = data[1];
  assign out2_data = data[2];
endmodule

// File: tb/tb_demux_1to3_buffered.sv
// tb_demux_1to3_buffered: scoreboard bench for demux_1to3_buffered.
module tb_demux_1to3_buffered;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready = '0;
  logic [31:0] out0_data, out1_data, out2_data;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb [3][$];
  int          m_drop = 0;
`ifdef DEMUX_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif
  demux_1to3_buffered #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data)
`ifdef DEMUX_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] odata(input int n);
    return n == 0 ? out0_data : n == 1 ? out1_data : out2_data;
  endfunction
  task automatic step(input logic v, input logic [1:0] sel, input logic [31:0] d, input logic [2:0] ordy);
    logic rdy;
    @(negedge clk);
    in_valid = v; in_sel = sel; in_data = d; out_ready = ordy;
    #1;
    if (sel == 2'b11) rdy = 1'b1;
    else rdy = sb[sel].size() == 0 || ordy[sel];
    check("in_ready", in_ready, rdy);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("out_valid%0d", n), out_valid[n], sb[n].size() != 0);
      if (sb[n].size() != 0) check($sformatf("out%0d_data", n), odata(n), sb[n][0]);
    end
`ifdef DEMUX_DROP_COUNT_EN
    check("drop_count", drop_count, m_drop);
`endif
    for (int n = 0; n < 3; n++)
      if (sb[n].size() != 0 && ordy[n]) void'(sb[n].pop_front());
    if (v && rdy) begin
      if (sel != 2'b11) sb[sel].push_back(d);
      else if (m_drop < 255) m_drop++;
    end
    @(posedge clk);
  endtask
  task automatic do_reset(input logic v, input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    rst = 1; in_valid = v; in_sel = sel; in_data = d; out_ready = 3'b000;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) sb[n].delete();
    m_drop = 0;
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_out0", out0_data, 0);
    check("rst_out1", out1_data, 0);
    check("rst_out2", out2_data, 0);
`ifdef DEMUX_DROP_COUNT_EN
    check("rst_drop_count", drop_count, 0);
`endif
    rst = 0; in_valid = 0;
  endtask
  initial begin
    do_reset(1'b0, 2'b00, 32'h0);
    step(1, 2'b01, 32'hDEADBEEF, 3'b000);
    step(1, 2'b01, 32'hBAD0BAD0, 3'b000);
    check("busy_sel1_blocked", in_ready, 1'b0);
    step(1, 2'b10, 32'hCAFEF00D, 3'b000);
    step(0, 2'b00, 32'h0, 3'b110);
    step(0, 2'b00, 32'h0, 3'b111);
    step(1, 2'b00, 32'h11, 3'b000);
    step(1, 2'b00, 32'h22, 3'b001);
    check("refill_ready", in_ready, 1'b1);
    step(0, 2'b00, 32'h0, 3'b000);
    check("refill_data", out0_data, 32'h22);
    step(0, 2'b00, 32'h0, 3'b001);
    for (int i = 1; i <= 8; i++) step(1, 2'b10, 32'(i), 3'b100);
    step(0, 2'b00, 32'h0, 3'b100);
    check("stream_last", out2_data, 32'h8);
    for (int i = 0; i < 300; i++) step(1, 2'b11, 32'(i), 3'b000);
    step(0, 2'b00, 32'h0, 3'b000);
`ifdef DEMUX_DROP_COUNT_EN
    check("drop_sat", drop_count, 8'hFF);
`endif
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)));
    step(1, 2'b00, 32'hA0, 3'b000);
    step(1, 2'b01, 32'hA1, 3'b000);
    step(1, 2'b10, 32'hA2, 3'b000);
    step(1, 2'b11, 32'hA3, 3'b000);
    step(0, 2'b00, 32'h0, 3'b000);
    check("all_full", out_valid, 3'b111);
    do_reset(1'b1, 2'b00, 32'h55);
    step(0, 2'b00, 32'h0, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
